// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: measures VGA HS/VS timing, locks onto the stream and rebuilds pixel position.
module vga_sync_monitor #(
  parameter int H_TOTAL = 800,
  parameter int H_SYNC = 96,
  parameter int H_SYNC_START = 656,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC = 2,
  parameter int V_SYNC_START = 490,
  parameter int V_ACTIVE = 480,
  parameter bit SYNC_POL = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  output logic [9:0] rx_h_count,
  output logic [9:0] rx_v_count,
  output logic       rx_visible,
  output logic       locked,
  output logic       frame_start,
  output logic       err_h,
  output logic       err_v
);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  state_t state;
  logic hs_r, vs_r, h_ref, v_ref, frame_bad;
  logic hs_lead, hs_trail, vs_lead, vs_trail, e_h, e_v, abort, go_lock, keep_lock;
  logic [9:0] h_cnt, l_cnt, vs_lines, h_nxt, v_nxt;
  logic [10:0] to_cnt;
  logic [7:0] good;
  // Edges are the clk at which the registered sync copy changes level.
  always_comb begin
    hs_lead = VGA_HS == SYNC_POL && hs_r != SYNC_POL;
    hs_trail = VGA_HS != SYNC_POL && hs_r == SYNC_POL;
    vs_lead = VGA_VS == SYNC_POL && vs_r != SYNC_POL;
    vs_trail = VGA_VS != SYNC_POL && vs_r == SYNC_POL;
    e_h = h_ref && ((hs_lead && {1'b0, h_cnt} + 11'd1 != 11'(H_TOTAL)) ||
                    (hs_trail && {1'b0, h_cnt} + 11'd1 != 11'(H_SYNC)) ||
                    (!hs_lead && to_cnt == 11'(2 * H_TOTAL - 1)));
    e_v = v_ref && ((vs_lead && {1'b0, l_cnt} + 11'(hs_lead) != 11'(V_TOTAL)) ||
                    (vs_trail && vs_lines != 10'(V_SYNC)));
    abort = state == LOCKED && (err_h || err_v);
    go_lock = state == TRACK && vs_lead && !e_h && !e_v && !frame_bad &&
              good + 8'd1 == 8'(LOCK_FRAMES);
    keep_lock = (state == LOCKED && !abort) || go_lock;
    h_nxt = hs_lead ? 10'(H_SYNC_START) :
            rx_h_count == 10'(H_TOTAL - 1) ? 10'd0 : rx_h_count + 10'd1;
    v_nxt = vs_lead ? 10'(V_SYNC_START) :
            (hs_lead || rx_h_count != 10'(H_TOTAL - 1)) ? rx_v_count :
            rx_v_count == 10'(V_TOTAL - 1) ? 10'd0 : rx_v_count + 10'd1;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= SEARCH;
      hs_r <= !SYNC_POL;
      vs_r <= !SYNC_POL;
      h_ref <= 1'b0;
      v_ref <= 1'b0;
      frame_bad <= 1'b0;
      h_cnt <= '0;
      l_cnt <= '0;
      vs_lines <= '0;
      to_cnt <= '0;
      good <= '0;
      rx_h_count <= '0;
      rx_v_count <= '0;
      rx_visible <= 1'b0;
      locked <= 1'b0;
      frame_start <= 1'b0;
      err_h <= 1'b0;
      err_v <= 1'b0;
    end else begin
      hs_r <= VGA_HS;
      vs_r <= VGA_VS;
      h_cnt <= hs_lead ? 10'd0 : h_cnt + 10'(h_cnt != 10'h3ff);
      to_cnt <= hs_lead ? 11'd0 : to_cnt + 11'(to_cnt != 11'(2 * H_TOTAL));
      l_cnt <= vs_lead ? 10'd0 : l_cnt + 10'(hs_lead && l_cnt != 10'h3ff);
      vs_lines <= vs_lead ? 10'(hs_lead) :
                  vs_lines + 10'(hs_lead && VGA_VS == SYNC_POL && vs_lines != 10'h3ff);
      h_ref <= !abort && (h_ref || hs_lead);
      v_ref <= !abort && (v_ref || vs_lead);
      err_h <= e_h;
      err_v <= e_v;
      locked <= keep_lock;
      frame_start <= keep_lock && vs_lead;
      rx_h_count <= keep_lock ? h_nxt : 10'd0;
      rx_v_count <= keep_lock ? v_nxt : 10'd0;
      rx_visible <= keep_lock && h_nxt < 10'(H_ACTIVE) && v_nxt < 10'(V_ACTIVE);
      // A frame only counts toward lock if no error was seen anywhere inside it.
      if (abort) begin
        state <= SEARCH;
        good <= '0;
        frame_bad <= 1'b0;
      end else if (state == SEARCH && vs_lead) begin
        state <= TRACK;
        good <= '0;
        frame_bad <= 1'b0;
      end else if (state == TRACK && vs_lead) begin
        state <= go_lock ? LOCKED : TRACK;
        good <= (e_h || e_v || frame_bad) ? 8'd0 : good + 8'd1;
        frame_bad <= 1'b0;
      end else if (state == TRACK && (e_h || e_v)) begin
        good <= '0;
        frame_bad <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed checks of sync measurement, locking, position rebuild and reset.
`timescale 1ns/1ps
module tb_vga_sync_monitor;
  localparam int HT = 40, HW = 6, HSS = 32, HA = 24;
  localparam int VT = 12, VW = 2, VSS = 8, VA = 6;
  logic clk = 1'b0, rst_n = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [9:0] rx_h, rx_v;
  logic vis, lck, fs, eh, ev;
  int checks = 0, fails = 0;
  int gh = 0, gv = 0, ph = 0, pv = 0, cyc = 0;
  int long_v = -1, short_v = -1, vtot = VT;
  bit hold = 1'b0, was_lck;
  int n_eh, n_ev, n_fs, n_vsl, eh_cyc, ev_cyc, fall_cyc, rise_cyc, rise_vsl;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_SYNC(HW), .H_SYNC_START(HSS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VW), .V_SYNC_START(VSS), .V_ACTIVE(VA),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .VGA_HS(hs), .VGA_VS(vs),
    .rx_h_count(rx_h), .rx_v_count(rx_v), .rx_visible(vis), .locked(lck),
    .frame_start(fs), .err_h(eh), .err_v(ev)
  );

  task automatic clear_stats();
    n_eh = 0; n_ev = 0; n_fs = 0; n_vsl = 0;
    eh_cyc = -1; ev_cyc = -1; fall_cyc = -1; rise_cyc = -1; rise_vsl = -1;
  endtask

  // One pixel clock of an active-low generator; VS edges coincide with HS leading edges.
  task automatic clk1();
    hs = hold || !(gh >= HSS && gh < HSS + (gv == short_v ? HW - 1 : HW));
    vs = hold || !((gv == VSS && gh >= HSS) || (gv > VSS && gv < VSS + VW) ||
                   (gv == VSS + VW && gh < HSS));
    was_lck = lck;
    @(posedge clk); #1;
    ph = gh; pv = gv; cyc++;
    if (!hold && gv == VSS && gh == HSS) n_vsl++;
    if (eh) begin n_eh++; if (eh_cyc < 0) eh_cyc = cyc; end
    if (ev) begin n_ev++; if (ev_cyc < 0) ev_cyc = cyc; end
    if (fs) n_fs++;
    if (was_lck && !lck && fall_cyc < 0) fall_cyc = cyc;
    if (!was_lck && lck && rise_cyc < 0) begin rise_cyc = cyc; rise_vsl = n_vsl; end
    gh++;
    if (gh == (gv == long_v ? HT + 1 : HT)) begin
      gh = 0;
      if (gv == long_v) long_v = -1;
      if (gv == short_v) short_v = -1;
      gv++;
      if (gv == vtot) begin gv = 0; vtot = VT; end
    end
  endtask

  task automatic goto_pos(input int v, input int h);
    for (int i = 0; i < 2 * HT * VT && !(gv == v && gh == h); i++) clk1();
  endtask

  task automatic run_to_lock();
    for (int i = 0; i < 6 * HT * VT && rise_cyc < 0; i++) clk1();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hs = 1'b0; vs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_h, rx_v, vis, lck, fs, eh, ev} !== 25'd0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", {rx_h, rx_v, vis, lck, fs, eh, ev});
    end
    @(negedge clk); hs = 1'b1; vs = 1'b1; rst_n = 1'b1;
  endtask

  task automatic test_lock();
    int bad_pos = 0, bad_vis = 0, bad_fs = 0;
    clear_stats();
    run_to_lock();
    checks++;
    if (rise_vsl != 3) begin fails++; $display("FAIL lock_edge: locked at VS edge %0d expected 3", rise_vsl); end
    checks++;
    if (rx_h !== 10'(HSS) || rx_v !== 10'(VSS)) begin
      fails++; $display("FAIL lock_pos: got %0d,%0d expected %0d,%0d", rx_h, rx_v, HSS, VSS);
    end
    checks++;
    if (n_eh + n_ev != 0) begin fails++; $display("FAIL lock_errs: got %0d err pulses expected 0", n_eh + n_ev); end
    clear_stats();
    for (int i = 0; i < 2 * HT * VT; i++) begin
      clk1();
      if (rx_h !== 10'(ph) || rx_v !== 10'(pv)) bad_pos++;
      if (vis !== 1'(ph < HA && pv < VA)) bad_vis++;
      if (fs !== 1'(pv == VSS && ph == HSS)) bad_fs++;
    end
    checks++;
    if (bad_pos != 0) begin fails++; $display("FAIL track_pos: %0d cycles wrong, last rx %0d,%0d expected %0d,%0d", bad_pos, rx_h, rx_v, ph, pv); end
    checks++;
    if (bad_vis != 0) begin fails++; $display("FAIL track_visible: %0d cycles wrong expected 0", bad_vis); end
    checks++;
    if (bad_fs != 0 || n_fs != 2) begin fails++; $display("FAIL track_frame_start: %0d wrong, %0d pulses expected 2", bad_fs, n_fs); end
    checks++;
    if (n_eh + n_ev != 0 || fall_cyc >= 0) begin
      fails++; $display("FAIL track_clean: errs %0d unlock cycle %0d expected none", n_eh + n_ev, fall_cyc);
    end
  endtask

  task automatic test_long_line();
    int exp_cyc = -1;
    goto_pos(1, 0);
    long_v = 2;
    clear_stats();
    for (int i = 0; i < 6 * HT * VT && rise_cyc < 0; i++) begin
      clk1();
      if (pv == 3 && ph == HSS && exp_cyc < 0) exp_cyc = cyc;
    end
    checks++;
    if (n_eh != 1 || eh_cyc != exp_cyc) begin
      fails++; $display("FAIL long_line_err: %0d pulses at %0d expected 1 at %0d", n_eh, eh_cyc, exp_cyc);
    end
    checks++;
    if (fall_cyc != exp_cyc + 1) begin fails++; $display("FAIL long_line_unlock: at %0d expected %0d", fall_cyc, exp_cyc + 1); end
    checks++;
    if (rise_vsl != 3 || n_ev != 0) begin
      fails++; $display("FAIL long_line_relock: VS edge %0d err_v %0d expected 3 and 0", rise_vsl, n_ev);
    end
  endtask

  task automatic test_short_hs();
    int exp_cyc = -1;
    goto_pos(3, 0);
    short_v = 4;
    clear_stats();
    for (int i = 0; i < 2 * HT; i++) begin
      clk1();
      if (pv == 4 && ph == HSS + HW - 1 && exp_cyc < 0) exp_cyc = cyc;
    end
    checks++;
    if (n_eh != 1 || eh_cyc != exp_cyc) begin
      fails++; $display("FAIL short_hs_err: %0d pulses at %0d expected 1 at %0d", n_eh, eh_cyc, exp_cyc);
    end
    checks++;
    if (fall_cyc != exp_cyc + 1 || lck !== 1'b0) begin
      fails++; $display("FAIL short_hs_unlock: at %0d locked %b expected %0d and 0", fall_cyc, lck, exp_cyc + 1);
    end
  endtask

  task automatic test_short_frame();
    int exp_cyc = -1;
    vtot = VT - 1;
    clear_stats();
    for (int i = 0; i < 6 * HT * VT && rise_cyc < 0; i++) begin
      clk1();
      if (n_vsl == 2 && exp_cyc < 0) exp_cyc = cyc;
    end
    checks++;
    if (n_ev != 1 || ev_cyc != exp_cyc) begin
      fails++; $display("FAIL short_frame_err: %0d pulses at %0d expected 1 at %0d", n_ev, ev_cyc, exp_cyc);
    end
    checks++;
    if (rise_vsl != 4 || n_eh != 0) begin
      fails++; $display("FAIL short_frame_relock: VS edge %0d err_h %0d expected 4 and 0", rise_vsl, n_eh);
    end
  endtask

  task automatic test_timeout();
    int lead_cyc;
    goto_pos(0, HSS);
    clk1();
    lead_cyc = cyc;
    goto_pos(1, 0);
    hold = 1'b1;
    clear_stats();
    for (int i = 0; i < 1200; i++) clk1();
    checks++;
    if (n_eh != 1 || eh_cyc != lead_cyc + 2 * HT) begin
      fails++; $display("FAIL timeout_err: %0d pulses at %0d expected 1 at %0d", n_eh, eh_cyc, lead_cyc + 2 * HT);
    end
    checks++;
    if (fall_cyc != eh_cyc + 1 || n_ev != 0) begin
      fails++; $display("FAIL timeout_unlock: at %0d err_v %0d expected %0d and 0", fall_cyc, n_ev, eh_cyc + 1);
    end
    checks++;
    if (dut.h_cnt !== 10'h3ff) begin fails++; $display("FAIL timeout_saturate: h count %0d expected 1023", dut.h_cnt); end
    goto_pos(1, 0);
    hold = 1'b0;
    clear_stats();
    run_to_lock();
    checks++;
    if (rise_vsl != 3 || n_eh + n_ev != 0) begin
      fails++; $display("FAIL timeout_relock: VS edge %0d errs %0d expected 3 and 0", rise_vsl, n_eh + n_ev);
    end
  endtask

  task automatic test_reset_mid();
    goto_pos(3, 10);
    checks++;
    if (lck !== 1'b1) begin fails++; $display("FAIL mid_reset_pre: locked %b expected 1", lck); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_h, rx_v, vis, lck, fs, eh, ev} !== 25'd0) begin
      fails++; $display("FAIL mid_reset_async: got %h expected 0", {rx_h, rx_v, vis, lck, fs, eh, ev});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    clear_stats();
    run_to_lock();
    checks++;
    if (rise_vsl != 3 || n_eh + n_ev != 0) begin
      fails++; $display("FAIL mid_reset_relock: VS edge %0d errs %0d expected 3 and 0", rise_vsl, n_eh + n_ev);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_long_line();
    test_short_hs();
    test_short_frame();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
